// File: rtl/aes_pkg.sv
// Shared register map constants, CTRL/STATUS bit positions and FSM state type for the AES CSR bank.
package aes_pkg;

    localparam int unsigned CTRL_ADDR   = 0;
    localparam int unsigned STATUS_ADDR = 1;
    localparam int unsigned KEY_BASE    = 2;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_MODE   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_ERR    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/aes_csr_bank.sv
// Memory-mapped control/status registers for the AES core: key/block/mode storage,
// start pulse generation, busy/done tracking and result capture.
module aes_csr_bank
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned BLK_WORDS = 4,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic                          read,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             writedata,
    output logic [DATA_W-1:0]             readdata,
    output logic                          irq,
    output logic                          start,
    output logic                          mode,
    output logic [KEY_WORDS*DATA_W-1:0]   key,
    output logic [BLK_WORDS*DATA_W-1:0]   block_in,
    input  logic                          core_done,
    input  logic [BLK_WORDS*DATA_W-1:0]   core_result
);

    localparam int unsigned DIN_BASE  = KEY_BASE + KEY_WORDS;
    localparam int unsigned DOUT_BASE = DIN_BASE + BLK_WORDS;

    state_t                        state;
    state_t                        state_d;
    logic                          start_d;
    logic                          irq_en;
    logic                          done;
    logic                          err;
    logic [BLK_WORDS*DATA_W-1:0]   dout;

    logic                          wr_c;
    logic                          rd_c;
    logic                          busy_c;
    logic                          ctrl_wr_c;
    logic                          status_wr_c;
    logic                          blocked_wr_c;
    logic [KEY_WORDS-1:0]          key_sel_c;
    logic [BLK_WORDS-1:0]          din_sel_c;
    logic [BLK_WORDS-1:0]          dout_sel_c;
    logic [DATA_W-1:0]             rd_word_c;

    // Address decode: one select bit per word of each array
    always_comb begin
        wr_c        = chipselect & write;
        rd_c        = chipselect & read;
        busy_c      = (state == BUSY);
        ctrl_wr_c   = wr_c && (address == ADDR_W'(CTRL_ADDR));
        status_wr_c = wr_c && (address == ADDR_W'(STATUS_ADDR));
        key_sel_c   = '0;
        din_sel_c   = '0;
        dout_sel_c  = '0;
        for (int unsigned i = 0; i < KEY_WORDS; i++) begin
            key_sel_c[i] = (address == ADDR_W'(KEY_BASE + i));
        end
        for (int unsigned i = 0; i < BLK_WORDS; i++) begin
            din_sel_c[i]  = (address == ADDR_W'(DIN_BASE + i));
            dout_sel_c[i] = (address == ADDR_W'(DOUT_BASE + i));
        end
        blocked_wr_c = busy_c && (ctrl_wr_c || (wr_c && ((|key_sel_c) || (|din_sel_c))));
    end

    // Next state and start pulse
    always_comb begin
        state_d = state;
        start_d = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr_c && writedata[CTRL_START]) begin
                    start_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            start <= 1'b0;
        end else begin
            state <= state_d;
            start <= start_d;
        end
    end

    // Read mux; START is write-only and unmapped words read as zero
    always_comb begin
        rd_word_c = '0;
        if (address == ADDR_W'(CTRL_ADDR)) begin
            rd_word_c[CTRL_MODE]   = mode;
            rd_word_c[CTRL_IRQ_EN] = irq_en;
        end
        if (address == ADDR_W'(STATUS_ADDR)) begin
            rd_word_c[STAT_BUSY] = busy_c;
            rd_word_c[STAT_DONE] = done;
            rd_word_c[STAT_ERR]  = err;
        end
        for (int unsigned i = 0; i < KEY_WORDS; i++) begin
            if (key_sel_c[i]) rd_word_c = key[i*DATA_W +: DATA_W];
        end
        for (int unsigned i = 0; i < BLK_WORDS; i++) begin
            if (din_sel_c[i])  rd_word_c = block_in[i*DATA_W +: DATA_W];
            if (dout_sel_c[i]) rd_word_c = dout[i*DATA_W +: DATA_W];
        end
    end

    // Host-writable configuration, frozen while the core is busy
    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= 1'b0;
            irq_en   <= 1'b0;
            key      <= '0;
            block_in <= '0;
        end else if (!busy_c && wr_c) begin
            if (ctrl_wr_c) begin
                mode   <= writedata[CTRL_MODE];
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                if (key_sel_c[i]) key[i*DATA_W +: DATA_W] <= writedata;
            end
            for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                if (din_sel_c[i]) block_in[i*DATA_W +: DATA_W] <= writedata;
            end
        end
    end

    // Status flags, result capture, read data and interrupt; a completion beats a DONE clear
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            err      <= 1'b0;
            dout     <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (busy_c && core_done) begin
                done <= 1'b1;
                dout <= core_result;
            end else if (status_wr_c && writedata[STAT_DONE]) begin
                done <= 1'b0;
            end
            if (blocked_wr_c) begin
                err <= 1'b1;
            end else if (status_wr_c && writedata[STAT_ERR]) begin
                err <= 1'b0;
            end
            if (rd_c) begin
                readdata <= rd_word_c;
            end
            irq <= done & irq_en;
        end
    end

endmodule

// File: tb/tb_aes_csr_bank.sv
// Bench for aes_csr_bank: directed vector table, corner sequences and random traffic
// checked against a register-map level model, for KEY_WORDS=4 and KEY_WORDS=8.
module tb_aes_csr_bank;

    localparam logic [127:0] RES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs, wr, rd, cd;
    logic [4:0]   addr;
    logic [31:0]  wdata;
    logic [127:0] cres;
    logic         sel;

    logic [31:0]  rd4, rd8;
    logic         irq4, irq8, start4, start8, mode4, mode8;
    logic [127:0] key4, bin4, bin8;
    logic [255:0] key8;

    logic [31:0]  rd_o;
    logic         irq_o, start_o, mode_o;
    logic [255:0] key_o;
    logic [127:0] bin_o;

    always #5 clk = ~clk;

    aes_csr_bank #(.DATA_W(32), .KEY_WORDS(4), .BLK_WORDS(4), .ADDR_W(5)) dut4 (
        .clk(clk), .reset(reset), .chipselect(cs & ~sel), .write(wr), .read(rd),
        .address(addr), .writedata(wdata), .readdata(rd4), .irq(irq4), .start(start4),
        .mode(mode4), .key(key4), .block_in(bin4), .core_done(cd & ~sel), .core_result(cres)
    );

    aes_csr_bank #(.DATA_W(32), .KEY_WORDS(8), .BLK_WORDS(4), .ADDR_W(5)) dut8 (
        .clk(clk), .reset(reset), .chipselect(cs & sel), .write(wr), .read(rd),
        .address(addr), .writedata(wdata), .readdata(rd8), .irq(irq8), .start(start8),
        .mode(mode8), .key(key8), .block_in(bin8), .core_done(cd & sel), .core_result(cres)
    );

    always_comb begin
        rd_o    = sel ? rd8 : rd4;
        irq_o   = sel ? irq8 : irq4;
        start_o = sel ? start8 : start4;
        mode_o  = sel ? mode8 : mode4;
        key_o   = sel ? key8 : {128'b0, key4};
        bin_o   = sel ? bin8 : bin4;
    end

    // Register-map model
    int          kw;
    logic [31:0] m_key [8];
    logic [31:0] m_din [4];
    logic [31:0] m_dout[4];
    logic        m_mode, m_irqen, m_done, m_err, m_busy;
    logic [31:0] m_rd;
    int          n_pass = 0;
    int          n_total = 0;

    typedef struct {
        bit          w;
        bit          r;
        int          a;
        logic [31:0] d;
        bit          c;
        bit          alt;
        logic [31:0] e;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit w, bit r, int a, logic [31:0] d, bit c, bit alt, logic [31:0] e);
        vec_t t;
        t.w = w; t.r = r; t.a = a; t.d = d; t.c = c; t.alt = alt; t.e = e;
        return t;
    endfunction

    function automatic logic [31:0] model_read(int a);
        if (a == 0) return {29'b0, m_irqen, m_mode, 1'b0};
        if (a == 1) return {29'b0, m_err, m_done, m_busy};
        if (a >= 2 && a < 2 + kw) return m_key[a-2];
        if (a >= 2 + kw && a < 6 + kw) return m_din[a-2-kw];
        if (a >= 6 + kw && a < 10 + kw) return m_dout[a-6-kw];
        return 32'h0;
    endfunction

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) m_key[j] = '0;
        for (int j = 0; j < 4; j++) begin
            m_din[j]  = '0;
            m_dout[j] = '0;
        end
        m_mode = 0; m_irqen = 0; m_done = 0; m_err = 0; m_busy = 0; m_rd = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; cs = 0; wr = 0; rd = 0; cd = 0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("reset_readdata", {224'b0, rd_o}, '0);
        check("reset_start", {255'b0, start_o}, '0);
        check("reset_irq", {255'b0, irq_o}, '0);
        check("reset_key", key_o, '0);
    endtask

    // One bus cycle with optional core_done; model updated from the map rules, then all outputs compared
    task automatic step(bit w, bit r, int a, logic [31:0] d, bit c, logic [127:0] res);
        logic         exp_irq, exp_start, pre_busy;
        logic [255:0] exp_key;
        logic [127:0] exp_bin;
        @(negedge clk);
        cs = w | r; wr = w; rd = r; addr = 5'(a); wdata = d; cd = c; cres = res;
        exp_irq   = m_done & m_irqen;
        pre_busy  = m_busy;
        exp_start = w && (a == 0) && d[0] && !pre_busy;
        if (r) m_rd = model_read(a);
        if (w) begin
            if (a == 0) begin
                if (pre_busy) m_err = 1;
                else begin
                    m_mode = d[1]; m_irqen = d[2];
                    if (d[0]) m_busy = 1;
                end
            end else if (a == 1) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end else if (a < 2 + kw) begin
                if (pre_busy) m_err = 1; else m_key[a-2] = d;
            end else if (a < 6 + kw) begin
                if (pre_busy) m_err = 1; else m_din[a-2-kw] = d;
            end
        end
        if (c && pre_busy) begin
            m_busy = 0; m_done = 1;
            for (int j = 0; j < 4; j++) m_dout[j] = res[j*32 +: 32];
        end
        @(posedge clk);
        #1;
        cs = 0; wr = 0; rd = 0; cd = 0;
        exp_key = '0;
        for (int j = 0; j < kw; j++) exp_key[j*32 +: 32] = m_key[j];
        for (int j = 0; j < 4; j++) exp_bin[j*32 +: 32] = m_din[j];
        check("readdata", {224'b0, rd_o}, {224'b0, m_rd});
        check("start", {255'b0, start_o}, {255'b0, exp_start});
        check("irq", {255'b0, irq_o}, {255'b0, exp_irq});
        check("mode", {255'b0, mode_o}, {255'b0, m_mode});
        check("key", key_o, exp_key);
        check("block_in", {128'b0, bin_o}, {128'b0, exp_bin});
    endtask

    task automatic rd_check(string name, int a, logic [31:0] e);
        step(0, 1, a, 32'h0, 0, 128'h0);
        check(name, {224'b0, rd_o}, {224'b0, e});
    endtask

    task automatic rand_run(int n);
        for (int k = 0; k < n; k++) begin
            int          op;
            int          a;
            logic [31:0] d;
            logic [127:0] res;
            op  = int'($urandom_range(0, 3));
            a   = int'($urandom_range(0, 11 + kw));
            d   = $urandom;
            res = {$urandom, $urandom, $urandom, $urandom};
            step(op == 1 || op == 3, op == 2, a, d, $urandom_range(0, 5) == 0, res);
        end
    endtask

    initial begin
        sel = 0; kw = 4; reset = 0; cs = 0; wr = 0; rd = 0; cd = 0;
        addr = '0; wdata = '0; cres = '0;
        model_reset();
        reset_dut();

        // Directed table for KEY_WORDS=4: KEY 2..5, DIN 6..9, DOUT 10..13
        tbl.push_back(v(0,1,1,0,0,0,32'h0));
        tbl.push_back(v(1,0,2,32'h03020100,0,0,0));
        tbl.push_back(v(1,0,3,32'h07060504,0,0,0));
        tbl.push_back(v(1,0,4,32'h0b0a0908,0,0,0));
        tbl.push_back(v(1,0,5,32'h0f0e0d0c,0,0,0));
        tbl.push_back(v(0,1,2,0,0,0,32'h03020100));
        tbl.push_back(v(0,1,3,0,0,0,32'h07060504));
        tbl.push_back(v(0,1,4,0,0,0,32'h0b0a0908));
        tbl.push_back(v(0,1,5,0,0,0,32'h0f0e0d0c));
        tbl.push_back(v(1,0,0,32'h5,0,0,0));
        tbl.push_back(v(0,1,1,0,0,0,32'h1));
        tbl.push_back(v(0,1,0,0,0,0,32'h4));
        tbl.push_back(v(0,0,0,0,1,0,0));
        tbl.push_back(v(0,1,10,0,0,0,32'h70b4c55a));
        tbl.push_back(v(0,1,11,0,0,0,32'hd8cdb780));
        tbl.push_back(v(0,1,12,0,0,0,32'h6a7b0430));
        tbl.push_back(v(0,1,13,0,0,0,32'h69c4e0d8));
        tbl.push_back(v(0,1,1,0,0,0,32'h2));
        tbl.push_back(v(1,0,1,32'h2,0,0,0));
        tbl.push_back(v(0,1,1,0,0,0,32'h0));
        tbl.push_back(v(1,0,0,32'h1,0,0,0));
        tbl.push_back(v(1,0,6,32'hdeadbeef,0,0,0));
        tbl.push_back(v(1,0,0,32'h3,0,0,0));
        tbl.push_back(v(0,1,6,0,0,0,32'h0));
        tbl.push_back(v(0,1,1,0,0,0,32'h5));
        tbl.push_back(v(0,0,0,0,1,0,0));
        tbl.push_back(v(0,1,1,0,0,0,32'h6));
        tbl.push_back(v(1,0,0,32'h1,0,0,0));
        tbl.push_back(v(1,0,1,32'h6,1,0,0));
        tbl.push_back(v(0,1,1,0,0,0,32'h2));
        tbl.push_back(v(0,0,0,0,1,1,0));
        tbl.push_back(v(0,1,10,0,0,0,32'h70b4c55a));
        tbl.push_back(v(1,0,0,32'h6,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,32'h6));
        tbl.push_back(v(0,1,20,0,0,0,32'h0));
        tbl.push_back(v(1,0,10,32'hffffffff,0,0,0));
        tbl.push_back(v(0,1,1,0,0,0,32'h2));
        tbl.push_back(v(0,1,10,0,0,0,32'h70b4c55a));

        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].alt ? ~RES : RES);
            if (tbl[i].r) check($sformatf("vec%0d", i), {224'b0, rd_o}, {224'b0, tbl[i].e});
        end
        check("key128_value", key_o, {128'b0, 128'h0f0e0d0c0b0a09080706050403020100});

        // Reset while busy, then a stale core_done must be ignored
        step(1, 0, 0, 32'h1, 0, RES);
        reset_dut();
        step(0, 0, 0, 32'h0, 1, RES);
        rd_check("abort_status", 1, 32'h0);
        rd_check("abort_dout0", 10, 32'h0);

        rand_run(600);

        // KEY_WORDS=8: KEY 2..9, DIN 10..13, DOUT 14..17
        sel = 1; kw = 8;
        reset_dut();
        for (int j = 0; j < 8; j++) step(1, 0, 2 + j, 32'h11111111 * (j + 1), 0, RES);
        for (int j = 0; j < 8; j++) rd_check($sformatf("k8_key%0d", j), 2 + j, 32'h11111111 * (j + 1));
        step(1, 0, 0, 32'h5, 0, RES);
        rd_check("k8_busy", 1, 32'h1);
        step(0, 0, 0, 32'h0, 1, RES);
        rd_check("k8_dout0", 14, 32'h70b4c55a);
        rd_check("k8_dout3", 17, 32'h69c4e0d8);
        rd_check("k8_done", 1, 32'h2);
        check("k8_irq_set", {255'b0, irq_o}, {255'b0, 1'b1});
        step(1, 0, 1, 32'h2, 0, RES);
        step(0, 0, 0, 32'h0, 0, RES);
        check("k8_irq_clr", {255'b0, irq_o}, '0);

        rand_run(600);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
